// File: rtl/counter_sequencer.sv
// Command sequencer: queues host commands in a small FIFO and replays
// them as load / decrement / halve strobes to an external 8-bit counter.
//
// Ports:
//   clk, reset_sink_reset        clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_data    host command offer (op: LOAD, COUNTDOWN, HALVE, WAIT)
//   cmd_ready                    FIFO has room this cycle
//   cnt_in, cnt_latch            load value and load strobe to counter
//   cnt_dec, cnt_div             decrement / halve strobes to counter
//   cnt_count                    counter value fed back for the COUNTDOWN check
//   busy, done, err              activity, completion pulse, sticky mismatch
//   fifo_level                   number of queued commands
module counter_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_sink_reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [7:0] cnt_in,
    output logic       cnt_latch,
    output logic       cnt_dec,
    output logic       cnt_div,
    input  logic [7:0] cnt_count,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CDOWN = 2'b01;
    localparam logic [1:0] OP_HALVE = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [1:0]    head_op;
    logic [7:0]    head_data;

    logic [2:0] state;
    logic [2:0] state_d;
    logic [1:0] op_q;
    logic [7:0] rpt;
    logic [7:0] rpt_d;

    // Ready comes only from the registered level, never from a same-cycle pop.
    assign cmd_ready = !reset_sink_reset && (fifo_level < DEPTH_L);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (fifo_level != 5'd0);
    assign head_op   = fifo_mem[rd_ptr][9:8];
    assign head_data = fifo_mem[rd_ptr][7:0];
    assign busy      = (state != S_IDLE) || (fifo_level != 5'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + 5'(push) - 5'(pop);
        end
    end

    // rpt holds the remaining repeat count; a state with count N exits
    // on the cycle where rpt reaches 1, giving exactly N strobe cycles.
    always_comb begin
        state_d = state;
        rpt_d   = rpt;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    rpt_d = head_data;
                    unique case (head_op)
                        OP_LOAD, OP_CDOWN: state_d = S_LATCH;
                        OP_HALVE: begin
                            rpt_d   = {4'd0, head_data[3:0]};
                            state_d = (head_data[3:0] == 4'd0) ? S_DONE : S_DIV;
                        end
                        default:
                            state_d = (head_data == 8'd0) ? S_DONE : S_WAIT;
                    endcase
                end
            end
            S_LATCH: begin
                if (op_q == OP_CDOWN) begin
                    state_d = (rpt == 8'd0) ? S_CHECK : S_DEC;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DEC: begin
                rpt_d = rpt - 8'd1;
                if (rpt == 8'd1) state_d = S_CHECK;
            end
            S_DIV: begin
                rpt_d = rpt - 8'd1;
                if (rpt == 8'd1) state_d = S_DONE;
            end
            S_WAIT: begin
                rpt_d = rpt - 8'd1;
                if (rpt == 8'd1) state_d = S_DONE;
            end
            S_CHECK: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are flops driven from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            state     <= S_IDLE;
            op_q      <= OP_LOAD;
            rpt       <= 8'd0;
            cnt_in    <= 8'd0;
            cnt_latch <= 1'b0;
            cnt_dec   <= 1'b0;
            cnt_div   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            rpt       <= rpt_d;
            cnt_latch <= (state_d == S_LATCH);
            cnt_dec   <= (state_d == S_DEC);
            cnt_div   <= (state_d == S_DIV);
            done      <= (state_d == S_DONE);
            if (pop) op_q <= head_op;
            if (state_d == S_LATCH) cnt_in <= head_data;
            if ((state == S_CHECK) && (cnt_count != 8'd0)) err <= 1'b1;
        end
    end

endmodule
